// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundle of the fetch, data and memory-side signals of the
//                unified memory port arbiter. The arbiter uses the slave
//                modport. The master modport is the pipeline/memory view.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Fetch-stage side
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;
    // Memory-stage side
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              d_stall;
    // Memory side
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    // Status
    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-ported unified memory between the fetch
//                stage (IF) and the memory stage (D). One access at a time,
//                fixed read latency MEM_LAT, data side has priority.
//                Optional macro MEM_PORT_ARB_STARVE_GUARD_EN: after
//                STARVE_LIMIT consecutive D grants with IF waiting, the next
//                contended grant goes to IF.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
    parameter int STARVE_LIMIT = 4,
`endif
    parameter int MEM_LAT      = 2
) (
    input  wire              clock,
    input  wire              reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    localparam logic [3:0] c_WAIT_LOAD = 4'(MEM_LAT - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_nextState;
    logic              r_ownD;
    logic              r_isWrite;
    logic [3:0]        r_waitCnt;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic [DATA_W-1:0] r_ifRdata;
    logic [DATA_W-1:0] r_dRdata;
    logic              w_grantD;
    logic              w_grantIf;
    logic              w_isIdle;

    assign w_isIdle = (r_state == c_IDLE);

`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] r_starveCnt;
    logic       w_starveHit;

    assign w_starveHit = (r_starveCnt == c_STARVE_LIMIT) && bus.if_req;

    // Grant selection: data first unless IF has waited through STARVE_LIMIT D grants
    always_comb begin
        w_grantD  = w_isIdle && bus.d_req && !w_starveHit;
        w_grantIf = w_isIdle && bus.if_req && !w_grantD;
    end

    // Count consecutive D grants taken while IF was waiting
    always_ff @(posedge clock) begin
        if (reset) begin
            r_starveCnt <= 4'd0;
        end else if (w_grantIf || (w_isIdle && !bus.if_req)) begin
            r_starveCnt <= 4'd0;
        end else if (w_grantD && bus.if_req && (r_starveCnt != 4'hF)) begin
            r_starveCnt <= r_starveCnt + 4'd1;
        end
    end
`else
    // Grant selection: strict data priority (older instruction wins)
    always_comb begin
        w_grantD  = w_isIdle && bus.d_req;
        w_grantIf = w_isIdle && bus.if_req && !bus.d_req;
    end
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: one access per pass through ISSUE, stores skip WAIT
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE:  if (w_grantD || w_grantIf) w_nextState = c_ISSUE;
            c_ISSUE: w_nextState = r_isWrite ? c_RESP : c_WAIT;
            c_WAIT:  if (r_waitCnt == 4'd0) w_nextState = c_RESP;
            c_RESP:  w_nextState = c_IDLE;
            default: w_nextState = c_IDLE;
        endcase
    end

    // Grant-edge capture of the access, latency counting and read-data capture
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ownD     <= 1'b0;
            r_isWrite  <= 1'b0;
            r_waitCnt  <= 4'd0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_ifRdata  <= '0;
            r_dRdata   <= '0;
        end else begin
            if (w_grantD || w_grantIf) begin
                r_ownD     <= w_grantD;
                r_isWrite  <= w_grantD && bus.d_we;
                r_memAddr  <= w_grantD ? {bus.d_addr[ADDR_W-1:2], 2'b00}
                                       : {bus.if_addr[ADDR_W-1:2], 2'b00};
                r_memWdata <= bus.d_wdata;
            end
            if (r_state == c_ISSUE) begin
                r_waitCnt <= c_WAIT_LOAD;
            end else if ((r_state == c_WAIT) && (r_waitCnt != 4'd0)) begin
                r_waitCnt <= r_waitCnt - 4'd1;
            end
            if ((r_state == c_WAIT) && (r_waitCnt == 4'd0)) begin
                if (r_ownD) begin
                    r_dRdata <= bus.mem_rdata;
                end else begin
                    r_ifRdata <= bus.mem_rdata;
                end
            end
        end
    end

    // Output decode: strobes and valid pulses come straight from the state
    always_comb begin
        bus.busy      = (r_state != c_IDLE);
        bus.mem_en    = (r_state == c_ISSUE);
        bus.mem_we    = (r_state == c_ISSUE) && r_isWrite;
        bus.mem_addr  = r_memAddr;
        bus.mem_wdata = r_memWdata;
        bus.if_valid  = (r_state == c_RESP) && !r_ownD;
        bus.d_valid   = (r_state == c_RESP) && r_ownD;
        bus.if_rdata  = r_ifRdata;
        bus.d_rdata   = r_dRdata;
        bus.if_stall  = bus.if_req && !((r_state == c_RESP) && !r_ownD);
        bus.d_stall   = bus.d_req && !((r_state == c_RESP) && r_ownD);
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed self-checking bench for mem_port_arbiter. Main DUT
//                runs MEM_LAT=2 against a small memory model; two more DUTs
//                with MEM_LAT=1 and MEM_LAT=15 cover the latency extremes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   nCompared   = 0;
    int   nMismatched = 0;

    always #5 clock = ~clock;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus15 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2))  u_dut0  (.clock(clock), .reset(reset), .bus(bus0));
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1))  u_dut1  (.clock(clock), .reset(reset), .bus(bus1));
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(15)) u_dut15 (.clock(clock), .reset(reset), .bus(bus15));

    // Memory model for the main DUT: data is only presented in the cycle
    // exactly MEM_LAT after the mem_en cycle, garbage otherwise.
    logic [31:0] mem [0:63];
    logic [3:0]  rd0, rd1, rd15;

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h2008_0005;
            rd0 <= 4'd0;
        end else begin
            if (bus0.mem_en && bus0.mem_we) mem[bus0.mem_addr[7:2]] <= bus0.mem_wdata;
            if (bus0.mem_en && !bus0.mem_we) rd0 <= 4'd2;
            else if (rd0 != 4'd0) rd0 <= rd0 - 4'd1;
        end
    end

    always @(posedge clock) begin
        if (reset) begin
            rd1  <= 4'd0;
            rd15 <= 4'd0;
        end else begin
            if (bus1.mem_en) rd1 <= 4'd1;
            else if (rd1 != 4'd0) rd1 <= rd1 - 4'd1;
            if (bus15.mem_en) rd15 <= 4'd15;
            else if (rd15 != 4'd0) rd15 <= rd15 - 4'd1;
        end
    end

    assign bus0.mem_rdata  = (rd0 == 4'd1)  ? mem[bus0.mem_addr[7:2]] : 32'h0BAD_0BAD;
    assign bus1.mem_rdata  = (rd1 == 4'd1)  ? 32'h600D_0001 : 32'h0BAD_0BAD;
    assign bus15.mem_rdata = (rd15 == 4'd1) ? 32'h600D_000F : 32'h0BAD_0BAD;

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) nextCycle();
        @(negedge clock);
        nCompared++;
        if (bus0.busy !== 1'b0 || bus0.mem_en !== 1'b0 || bus0.mem_we !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_ctrl: busy=%b mem_en=%b mem_we=%b, required 0 0 0", bus0.busy, bus0.mem_en, bus0.mem_we);
        end
        nCompared++;
        if (bus0.if_valid !== 1'b0 || bus0.d_valid !== 1'b0 || bus0.if_stall !== 1'b0 || bus0.d_stall !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_handshake: if_valid=%b d_valid=%b if_stall=%b d_stall=%b, required all 0",
                     bus0.if_valid, bus0.d_valid, bus0.if_stall, bus0.d_stall);
        end
        nCompared++;
        if (bus0.if_rdata !== 32'h0 || bus0.d_rdata !== 32'h0 || bus0.mem_addr !== 32'h0 || bus0.mem_wdata !== 32'h0) begin
            nMismatched++;
            $display("FAIL reset_data: if_rdata=%h d_rdata=%h mem_addr=%h mem_wdata=%h, required all 0",
                     bus0.if_rdata, bus0.d_rdata, bus0.mem_addr, bus0.mem_wdata);
        end
        nextCycle();
        reset = 1'b0;
        nextCycle();
    endtask

    task automatic test_single_fetch();
        bus0.if_req  = 1'b1;
        bus0.if_addr = 32'h0000_0010;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clock);
            nCompared++;
            if (bus0.mem_en !== (k == 1) || bus0.if_valid !== (k == 4) || bus0.if_stall !== (k <= 3)
                || bus0.busy !== (k >= 1 && k <= 4)) begin
                nMismatched++;
                $display("FAIL fetch_timing t+%0d: mem_en=%b if_valid=%b if_stall=%b busy=%b, required %b %b %b %b",
                         k, bus0.mem_en, bus0.if_valid, bus0.if_stall, bus0.busy,
                         (k == 1), (k == 4), (k <= 3), (k >= 1 && k <= 4));
            end
            if (k == 1) begin
                nCompared++;
                if (bus0.mem_addr !== 32'h10 || bus0.mem_we !== 1'b0) begin
                    nMismatched++;
                    $display("FAIL fetch_addr: mem_addr=%h mem_we=%b, required 00000010 0", bus0.mem_addr, bus0.mem_we);
                end
            end
            if (k == 4) begin
                nCompared++;
                if (bus0.if_rdata !== 32'h2008_0005) begin
                    nMismatched++;
                    $display("FAIL fetch_data: if_rdata=%h, required 20080005", bus0.if_rdata);
                end
            end
            nextCycle();
            if (k == 4) bus0.if_req = 1'b0;
        end
    endtask

    task automatic test_store_load();
        bus0.d_req   = 1'b1;
        bus0.d_we    = 1'b1;
        bus0.d_addr  = 32'h0000_0103;
        bus0.d_wdata = 32'hDEAD_BEEF;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clock);
            nCompared++;
            if (bus0.mem_en !== (k == 1) || bus0.mem_we !== (k == 1) || bus0.d_valid !== (k == 2)
                || bus0.d_stall !== (k <= 1)) begin
                nMismatched++;
                $display("FAIL store_timing t+%0d: mem_en=%b mem_we=%b d_valid=%b d_stall=%b, required %b %b %b %b",
                         k, bus0.mem_en, bus0.mem_we, bus0.d_valid, bus0.d_stall, (k == 1), (k == 1), (k == 2), (k <= 1));
            end
            if (k == 1) begin
                nCompared++;
                if (bus0.mem_addr !== 32'h100 || bus0.mem_wdata !== 32'hDEAD_BEEF) begin
                    nMismatched++;
                    $display("FAIL store_bus: mem_addr=%h mem_wdata=%h, required 00000100 deadbeef", bus0.mem_addr, bus0.mem_wdata);
                end
            end
            nextCycle();
            if (k == 2) bus0.d_req = 1'b0;
        end
        bus0.d_req  = 1'b1;
        bus0.d_we   = 1'b0;
        bus0.d_addr = 32'h0000_0100;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clock);
            nCompared++;
            if (bus0.mem_en !== (k == 1) || bus0.mem_we !== 1'b0 || bus0.d_valid !== (k == 4)) begin
                nMismatched++;
                $display("FAIL load_timing t+%0d: mem_en=%b mem_we=%b d_valid=%b, required %b 0 %b",
                         k, bus0.mem_en, bus0.mem_we, bus0.d_valid, (k == 1), (k == 4));
            end
            if (k == 4) begin
                nCompared++;
                if (bus0.d_rdata !== 32'hDEAD_BEEF) begin
                    nMismatched++;
                    $display("FAIL load_data: d_rdata=%h, required deadbeef", bus0.d_rdata);
                end
            end
            nextCycle();
            if (k == 4) bus0.d_req = 1'b0;
        end
    endtask

    task automatic test_contention();
        bus0.if_req  = 1'b1;
        bus0.if_addr = 32'h0000_0012;
        bus0.d_req   = 1'b1;
        bus0.d_we    = 1'b0;
        bus0.d_addr  = 32'h0000_0100;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clock);
            nCompared++;
            if (bus0.mem_en !== (k == 1 || k == 6) || bus0.d_valid !== (k == 4) || bus0.if_valid !== (k == 9)
                || bus0.if_stall !== (k <= 8) || bus0.d_stall !== (k <= 3)) begin
                nMismatched++;
                $display("FAIL contention t+%0d: mem_en=%b d_valid=%b if_valid=%b if_stall=%b d_stall=%b, required %b %b %b %b %b",
                         k, bus0.mem_en, bus0.d_valid, bus0.if_valid, bus0.if_stall, bus0.d_stall,
                         (k == 1 || k == 6), (k == 4), (k == 9), (k <= 8), (k <= 3));
            end
            if (k == 6) begin
                nCompared++;
                if (bus0.mem_addr !== 32'h10) begin
                    nMismatched++;
                    $display("FAIL contention_if_addr: mem_addr=%h, required 00000010", bus0.mem_addr);
                end
            end
            if (k == 9) begin
                nCompared++;
                if (bus0.if_rdata !== 32'h2008_0005 || bus0.d_rdata !== 32'hDEAD_BEEF) begin
                    nMismatched++;
                    $display("FAIL contention_data: if_rdata=%h d_rdata=%h, required 20080005 deadbeef", bus0.if_rdata, bus0.d_rdata);
                end
            end
            nextCycle();
            if (k == 4) bus0.d_req = 1'b0;
            if (k == 9) bus0.if_req = 1'b0;
        end
    endtask

    task automatic test_reset_midop();
        bus0.if_req  = 1'b1;
        bus0.if_addr = 32'h0000_0010;
        nextCycle();
        nextCycle();
        reset = 1'b1;
        bus0.if_req = 1'b0;
        nextCycle();
        reset = 1'b0;
        for (int k = 3; k <= 6; k++) begin
            @(negedge clock);
            if (k == 3) begin
                nCompared++;
                if (bus0.busy !== 1'b0 || bus0.mem_en !== 1'b0 || bus0.if_rdata !== 32'h0) begin
                    nMismatched++;
                    $display("FAIL midop_reset: busy=%b mem_en=%b if_rdata=%h, required 0 0 00000000",
                             bus0.busy, bus0.mem_en, bus0.if_rdata);
                end
            end
            nCompared++;
            if (bus0.if_valid !== 1'b0 || bus0.busy !== 1'b0) begin
                nMismatched++;
                $display("FAIL midop_no_valid t+%0d: if_valid=%b busy=%b, required 0 0", k, bus0.if_valid, bus0.busy);
            end
            nextCycle();
        end
        bus0.if_req = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clock);
            nCompared++;
            if (bus0.if_valid !== (k == 4) || bus0.mem_en !== (k == 1)) begin
                nMismatched++;
                $display("FAIL after_reset_fetch t+%0d: if_valid=%b mem_en=%b, required %b %b",
                         k, bus0.if_valid, bus0.mem_en, (k == 4), (k == 1));
            end
            if (k == 4) begin
                nCompared++;
                if (bus0.if_rdata !== 32'h2008_0005) begin
                    nMismatched++;
                    $display("FAIL after_reset_data: if_rdata=%h, required 20080005", bus0.if_rdata);
                end
            end
            nextCycle();
            if (k == 4) bus0.if_req = 1'b0;
        end
    endtask

    task automatic test_latency_sweep();
        bus1.if_req   = 1'b1;
        bus1.if_addr  = 32'h0000_0020;
        bus15.if_req  = 1'b1;
        bus15.if_addr = 32'h0000_0020;
        for (int k = 0; k <= 19; k++) begin
            @(negedge clock);
            nCompared++;
            if (bus1.if_valid !== (k == 3) || bus1.busy !== (k >= 1 && k <= 3)) begin
                nMismatched++;
                $display("FAIL lat1 t+%0d: if_valid=%b busy=%b, required %b %b",
                         k, bus1.if_valid, bus1.busy, (k == 3), (k >= 1 && k <= 3));
            end
            nCompared++;
            if (bus15.if_valid !== (k == 17) || bus15.busy !== (k >= 1 && k <= 17)) begin
                nMismatched++;
                $display("FAIL lat15 t+%0d: if_valid=%b busy=%b, required %b %b",
                         k, bus15.if_valid, bus15.busy, (k == 17), (k >= 1 && k <= 17));
            end
            if (k == 3) begin
                nCompared++;
                if (bus1.if_rdata !== 32'h600D_0001) begin
                    nMismatched++;
                    $display("FAIL lat1_data: if_rdata=%h, required 600d0001", bus1.if_rdata);
                end
            end
            if (k == 17) begin
                nCompared++;
                if (bus15.if_rdata !== 32'h600D_000F) begin
                    nMismatched++;
                    $display("FAIL lat15_data: if_rdata=%h, required 600d000f", bus15.if_rdata);
                end
            end
            nextCycle();
            if (k == 3) bus1.if_req = 1'b0;
            if (k == 17) bus15.if_req = 1'b0;
        end
    endtask

    task automatic test_starvation();
        string grants;
        int    ifGrants;
        int    dGrants;
        grants   = "";
        ifGrants = 0;
        dGrants  = 0;
        bus0.d_req   = 1'b1;
        bus0.d_we    = 1'b1;
        bus0.d_addr  = 32'h0000_0200;
        bus0.d_wdata = 32'h1234_5678;
        bus0.if_req  = 1'b1;
        bus0.if_addr = 32'h0000_0010;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (bus0.mem_en) begin
                if (bus0.mem_we) begin
                    dGrants++;
                    if (grants.len() < 6) grants = {grants, "D"};
                end else begin
                    ifGrants++;
                    if (grants.len() < 6) grants = {grants, "I"};
                end
            end
            nextCycle();
            if (bus0.if_valid) bus0.if_req = 1'b0;
        end
        bus0.d_req  = 1'b0;
        bus0.if_req = 1'b0;
`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
        nCompared++;
        if (grants != "DDDDID") begin
            nMismatched++;
            $display("FAIL starve_order: grant sequence %s, required DDDDID", grants);
        end
        nCompared++;
        if (ifGrants != 1) begin
            nMismatched++;
            $display("FAIL starve_if_count: if grants %0d, required 1", ifGrants);
        end
`else
        nCompared++;
        if (ifGrants != 0) begin
            nMismatched++;
            $display("FAIL starve_strict: if grants %0d (sequence %s), required 0", ifGrants, grants);
        end
        nCompared++;
        if (dGrants < 10) begin
            nMismatched++;
            $display("FAIL starve_d_count: d grants %0d, required at least 10", dGrants);
        end
`endif
        repeat (8) nextCycle();
        @(negedge clock);
        nCompared++;
        if (bus0.busy !== 1'b0) begin
            nMismatched++;
            $display("FAIL starve_drain: busy=%b, required 0", bus0.busy);
        end
    endtask

    initial begin
        bus0.if_req = 1'b0;  bus0.if_addr = '0;  bus0.d_req = 1'b0;  bus0.d_we = 1'b0;
        bus0.d_addr = '0;    bus0.d_wdata = '0;
        bus1.if_req = 1'b0;  bus1.if_addr = '0;  bus1.d_req = 1'b0;  bus1.d_we = 1'b0;
        bus1.d_addr = '0;    bus1.d_wdata = '0;
        bus15.if_req = 1'b0; bus15.if_addr = '0; bus15.d_req = 1'b0; bus15.d_we = 1'b0;
        bus15.d_addr = '0;   bus15.d_wdata = '0;
        test_reset();
        test_single_fetch();
        nextCycle();
        test_store_load();
        nextCycle();
        test_contention();
        nextCycle();
        test_reset_midop();
        nextCycle();
        test_latency_sweep();
        nextCycle();
        test_starvation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
